lane_hit_judge: RTL

Player-input front end and hit judge for one note lane. It conditions a raw switch or key into clean press events, then judges each press against the note currently at the lane's target position. It emits single-cycle hit/miss strobes and a running combo count. It sits between the board input pins and the lane/score stage: it consumes the lane's target bit and shift strobe, and feeds one-cycle increment and decrement requests to the score counter.

---
 rtl/lane_hit_judge_if.sv | 22 ++
 rtl/lane_hit_judge.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lane_hit_judge_if.sv
// Signal bundle between the lane/score stage and the lane hit judge.
// The master drives game and lane state; the slave (the judge) returns pulses and combo.
interface lane_hit_judge_if;
  logic       running;
  logic       btn_raw;
  logic       note_at_target;
  logic       lane_step;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] combo;
  logic       btn_level;

  modport master (
    output running, btn_raw, note_at_target, lane_step,
    input  hit_pulse, miss_pulse, combo, btn_level
  );

  modport slave (
    input  running, btn_raw, note_at_target, lane_step,
    output hit_pulse, miss_pulse, combo, btn_level
  );
endinterface

// File: rtl/lane_hit_judge.sv
// Single-lane player input conditioner and hit judge: synchronize, debounce,
// then judge each accepted press against the note at the target position.
module lane_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             reset,
  lane_hit_judge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level_q, btn_level_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             miss_pulse_q, miss_pulse_d;
  logic [7:0]       combo_q, combo_d;
  logic             judged_q, judged_d;
  logic             sync_s;
  logic             press_evt;

  assign sync_s = sync_q[1];

  // Debounce: a counter that has reached the limit means the required number of
  // stable samples has been seen, so the transition wins over the current sample.
  always_comb begin
    sync_d    = {sync_q[0], bus.btn_raw};
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (cnt_q == DB_MAX) begin
          state_d   = HELD;
          cnt_d     = '0;
          press_evt = 1'b1;
        end else if (!sync_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (cnt_q == DB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sync_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    btn_level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  // Judgement uses the pre-step judged flag; a same-cycle hit suppresses expiry.
  always_comb begin
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    combo_d      = combo_q;
    judged_d     = judged_q;
    if (!bus.running) begin
      combo_d  = 8'd0;
      judged_d = 1'b0;
    end else begin
      hit_pulse_d  = press_evt && bus.note_at_target && !judged_q;
      miss_pulse_d = (press_evt && (!bus.note_at_target || judged_q)) ||
                     (bus.lane_step && bus.note_at_target && !judged_q && !hit_pulse_d);
      if (hit_pulse_d) begin
        combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
      end else if (miss_pulse_d) begin
        combo_d = 8'd0;
      end
      if (bus.lane_step) begin
        judged_d = 1'b0;
      end else if (hit_pulse_d) begin
        judged_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= 2'b00;
      state_q      <= IDLE;
      cnt_q        <= '0;
      btn_level_q  <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      combo_q      <= 8'd0;
      judged_q     <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      btn_level_q  <= btn_level_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      combo_q      <= combo_d;
      judged_q     <= judged_d;
    end
  end

  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.combo      = combo_q;
  assign bus.btn_level  = btn_level_q;

  a_one_pulse : assert property (@(posedge clk) disable iff (reset)
                                 !(hit_pulse_q && miss_pulse_q));

endmodule
